// File: rtl/mmio_init_pkg.sv
// Shared types and constants for the host-side MMIO request generator.
package mmio_init_pkg;

    localparam int         MMIO_TID_W  = 9;
    localparam logic [1:0] MMIO_LEN_8B = 2'b01;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } mmio_init_state_e;

endpackage

// File: rtl/mmio_initiator.sv
// Host-side MMIO initiator: turns single read/write commands into CCI-P c0
// MMIO request pulses and, for reads, waits for the tid-matched c2 response.
module mmio_initiator
    import mmio_init_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int STRAY_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [15:0]           cmd_addr,
    input  logic [63:0]           cmd_data,
    output logic                  mmio_wr_valid,
    output logic                  mmio_rd_valid,
    output logic [15:0]           mmio_addr,
    output logic [1:0]            mmio_length,
    output logic [MMIO_TID_W-1:0] mmio_tid,
    output logic [63:0]           mmio_data,
    input  logic                  rsp_valid,
    input  logic [MMIO_TID_W-1:0] rsp_tid,
    input  logic [63:0]           rsp_data,
    output logic                  done_valid,
    output logic [63:0]           done_data,
    output logic                  done_timeout,
    output logic [STRAY_W-1:0]    stray_cnt
);

    // Wide enough to hold TIMEOUT_CYCLES-1, the last value the counter reaches.
    localparam int              TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    mmio_init_state_e      state;
    mmio_init_state_e      state_next;
    logic                  lat_write;
    logic [MMIO_TID_W-1:0] tid_cnt;
    logic [TO_W-1:0]       to_cnt;
    logic                  rsp_match;
    logic                  to_expired;

    // A response only completes a read when we are waiting and the tid is ours;
    // everything else on the response port is stray.
    assign rsp_match  = (state == WAIT_RSP) && rsp_valid && (rsp_tid == mmio_tid);
    assign to_expired = (to_cnt == TO_LAST);

    assign mmio_length = MMIO_LEN_8B;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of evaluation order.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode; a match takes priority over a same-cycle timeout.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        case (state)
            IDLE:     if (cmd_valid) state_next = ISSUE;
            ISSUE:    state_next = lat_write ? DONE : WAIT_RSP;
            WAIT_RSP: if (rsp_match || to_expired) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Pulse and handshake outputs decoded straight from the state.
    always_comb begin
        cmd_ready     = (state == IDLE);
        mmio_wr_valid = (state == ISSUE) &&  lat_write;
        mmio_rd_valid = (state == ISSUE) && !lat_write;
        done_valid    = (state == DONE);
    end

    // Command latch, tid allocation, timeout counting and completion capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_write    <= 1'b0;
            mmio_addr    <= '0;
            mmio_tid     <= '0;
            mmio_data    <= '0;
            tid_cnt      <= '0;
            to_cnt       <= '0;
            done_data    <= '0;
            done_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        lat_write    <= cmd_write;
                        mmio_addr    <= cmd_addr;
                        mmio_data    <= cmd_write ? cmd_data : 64'd0;
                        mmio_tid     <= tid_cnt;
                        done_data    <= 64'd0;
                        done_timeout <= 1'b0;
                    end
                end
                ISSUE: begin
                    // Only reads consume a tid; the 9-bit counter wraps 511 -> 0.
                    if (!lat_write) tid_cnt <= tid_cnt + 1'b1;
                    to_cnt <= '0;
                end
                WAIT_RSP: begin
                    if (rsp_match)       done_data    <= rsp_data;
                    else if (to_expired) done_timeout <= 1'b1;
                    else                 to_cnt       <= to_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Saturating count of responses that did not complete the pending read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stray_cnt <= '0;
        end else if (rsp_valid && !rsp_match && (stray_cnt != '1)) begin
            stray_cnt <= stray_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mmio_initiator.sv
// Self-checking bench for mmio_initiator: per-feature tasks plus a completion
// scoreboard that is filled when a command is issued and drained on done_valid.
module tb_mmio_initiator;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [63:0] cmd_data = '0;
    logic        mmio_wr_valid;
    logic        mmio_rd_valid;
    logic [15:0] mmio_addr;
    logic [1:0]  mmio_length;
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_data;
    logic        rsp_valid = 1'b0;
    logic [8:0]  rsp_tid = '0;
    logic [63:0] rsp_data = '0;
    logic        done_valid;
    logic [63:0] done_data;
    logic        done_timeout;
    logic [7:0]  stray_cnt;

    typedef struct {
        logic [63:0] data;
        logic        timeout;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_tid = '0;
    logic [7:0] exp_stray = '0;

    mmio_initiator #(.TIMEOUT_CYCLES(TO), .STRAY_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
        .mmio_addr(mmio_addr), .mmio_length(mmio_length), .mmio_tid(mmio_tid),
        .mmio_data(mmio_data),
        .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
        .done_valid(done_valid), .done_data(done_data), .done_timeout(done_timeout),
        .stray_cnt(stray_cnt)
    );

    always #5 clk = ~clk;

    // Completion scoreboard: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got data=%h timeout=%b, required no completion",
                         done_data, done_timeout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (done_data !== e.data || done_timeout !== e.timeout) begin
                    errors++;
                    $display("FAIL done_result: got data=%h timeout=%b, required data=%h timeout=%b",
                             done_data, done_timeout, e.data, e.timeout);
                end
            end
        end
    end

    // All tasks start and end #1 after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one command, return in its ISSUE cycle after checking the request.
    task automatic send(input logic wr, input logic [15:0] addr, input logic [63:0] data,
                        output logic [8:0] tid);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_wait: got %b, required 1 within 50 cycles", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
        cmd_data  = '0;
        tid = exp_tid;
        checks++;
        if (mmio_wr_valid !== wr || mmio_rd_valid !== !wr || mmio_addr !== addr ||
            mmio_tid !== exp_tid || mmio_data !== (wr ? data : 64'd0) ||
            mmio_length !== 2'b01 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL issue_req: got wr=%b rd=%b addr=%h tid=%0d data=%h len=%b rdy=%b, required wr=%b rd=%b addr=%h tid=%0d data=%h len=01 rdy=0",
                     mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_data, mmio_length,
                     cmd_ready, wr, !wr, addr, exp_tid, wr ? data : 64'd0);
        end
        if (!wr) exp_tid = exp_tid + 9'd1;
    endtask

    // Count cycles from the ISSUE cycle until done_valid (bounded).
    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (!done_valid && cyc < max) begin
            step();
            cyc++;
        end
    endtask

    // Drive one response cycle; returns in the following cycle.
    task automatic respond(input logic [8:0] tid, input logic [63:0] data);
        rsp_valid = 1'b1;
        rsp_tid   = tid;
        rsp_data  = data;
        step();
        rsp_valid = 1'b0;
        rsp_data  = '0;
    endtask

    task automatic test_reset();
        checks++;
        if (cmd_ready !== 1'b1 || mmio_wr_valid !== 1'b0 || mmio_rd_valid !== 1'b0 ||
            mmio_addr !== 16'd0 || mmio_tid !== 9'd0 || mmio_data !== 64'd0 ||
            mmio_length !== 2'b01 || done_valid !== 1'b0 || done_data !== 64'd0 ||
            done_timeout !== 1'b0 || stray_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b wr=%b rd=%b addr=%h tid=%0d data=%h len=%b done=%b dd=%h to=%b stray=%0d, required rdy=1 len=01 rest 0",
                     cmd_ready, mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_data,
                     mmio_length, done_valid, done_data, done_timeout, stray_cnt);
        end
    endtask

    task automatic test_write();
        logic [8:0] tid;
        int cyc;
        sb.push_back('{data: 64'd0, timeout: 1'b0});
        send(1'b1, 16'h0020, 64'hA5A5_0000_1234_5678, tid);
        wait_done(20, cyc);
        checks++;
        if (cyc !== 1) begin
            errors++;
            $display("FAIL write_done_latency: got %0d cycles after issue, required 1", cyc);
        end
        step();
        checks++;
        if (cmd_ready !== 1'b1 || done_valid !== 1'b0 || mmio_wr_valid !== 1'b0 ||
            mmio_addr !== 16'h0020 || mmio_data !== 64'hA5A5_0000_1234_5678) begin
            errors++;
            $display("FAIL write_after: got rdy=%b done=%b wr=%b addr=%h data=%h, required rdy=1 done=0 wr=0 addr=0020 data=a5a5000012345678",
                     cmd_ready, done_valid, mmio_wr_valid, mmio_addr, mmio_data);
        end
    endtask

    task automatic test_read();
        logic [8:0] tid;
        sb.push_back('{data: 64'hCAFE, timeout: 1'b0});
        send(1'b0, 16'h0020, 64'hFFFF_FFFF_FFFF_FFFF, tid);
        step();
        step();
        respond(tid, 64'hCAFE);
        checks++;
        if (done_valid !== 1'b1) begin
            errors++;
            $display("FAIL read_done_latency: got done_valid=%b at R+1, required 1", done_valid);
        end
        step();
        // The following read must carry tid 1; send() checks mmio_tid.
        sb.push_back('{data: 64'h1111_2222_3333_4444, timeout: 1'b0});
        send(1'b0, 16'h0024, 64'd0, tid);
        checks++;
        if (tid !== 9'd1) begin
            errors++;
            $display("FAIL read_next_tid: got %0d, required 1", tid);
        end
        step();
        respond(tid, 64'h1111_2222_3333_4444);
        step();
    endtask

    task automatic test_stray_tid();
        logic [8:0] tid;
        sb.push_back('{data: 64'hBEEF_0001, timeout: 1'b0});
        send(1'b0, 16'h0100, 64'd0, tid);
        // A response in the ISSUE cycle itself is never matched.
        respond(tid, 64'hDEAD);
        exp_stray++;
        respond(tid ^ 9'h001, 64'hDEAD_DEAD);
        exp_stray++;
        checks++;
        if (stray_cnt !== exp_stray || done_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_wrong_tid: got stray=%0d done=%b, required stray=%0d done=0",
                     stray_cnt, done_valid, exp_stray);
        end
        respond(tid, 64'hBEEF_0001);
        checks++;
        if (done_valid !== 1'b1 || stray_cnt !== exp_stray) begin
            errors++;
            $display("FAIL stray_then_match: got done=%b stray=%0d, required done=1 stray=%0d",
                     done_valid, stray_cnt, exp_stray);
        end
        step();
    endtask

    task automatic test_timeout();
        logic [8:0] tid;
        int cyc;
        sb.push_back('{data: 64'd0, timeout: 1'b1});
        send(1'b0, 16'h0200, 64'd0, tid);
        wait_done(40, cyc);
        checks++;
        if (cyc !== TO + 1) begin
            errors++;
            $display("FAIL timeout_latency: got done %0d cycles after issue, required %0d",
                     cyc, TO + 1);
        end
        step();
        respond(tid, 64'h5555);
        exp_stray++;
        checks++;
        if (stray_cnt !== exp_stray || done_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_late_rsp: got stray=%0d done=%b, required stray=%0d done=0",
                     stray_cnt, done_valid, exp_stray);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0]  tid;
        logic [63:0] d;
        bit          wrapped = 0;
        for (int i = 0; i < 513; i++) begin
            d = {$urandom(), $urandom()};
            sb.push_back('{data: d, timeout: 1'b0});
            send(1'b0, 16'(i), 64'd0, tid);
            if (tid == 9'd511) wrapped = 1;
            step();
            respond(tid, d);
            step();
        end
        checks++;
        if (!wrapped || exp_tid !== mmio_tid + 9'd1 || sb.size() != 0) begin
            errors++;
            $display("FAIL tid_wrap: got wrapped=%0d last_tid=%0d pending=%0d, required wrapped=1 last_tid=%0d pending=0",
                     wrapped, mmio_tid, sb.size(), exp_tid - 9'd1);
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] tid;
        send(1'b0, 16'h0300, 64'd0, tid);
        step();
        rst_n = 1'b0;
        #1;
        exp_tid   = '0;
        exp_stray = '0;
        checks++;
        if (cmd_ready !== 1'b1 || mmio_rd_valid !== 1'b0 || mmio_addr !== 16'd0 ||
            mmio_tid !== 9'd0 || done_valid !== 1'b0 || done_data !== 64'd0 ||
            stray_cnt !== 8'd0 || mmio_length !== 2'b01) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b rd=%b addr=%h tid=%0d done=%b dd=%h stray=%0d len=%b, required rdy=1 len=01 rest 0",
                     cmd_ready, mmio_rd_valid, mmio_addr, mmio_tid, done_valid, done_data,
                     stray_cnt, mmio_length);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        respond(tid, 64'h7777);
        exp_stray++;
        checks++;
        if (stray_cnt !== exp_stray || done_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_late_rsp: got stray=%0d done=%b, required stray=%0d done=0",
                     stray_cnt, done_valid, exp_stray);
        end
        // After reset the tid counter restarts at 0; send() checks it.
        sb.push_back('{data: 64'd0, timeout: 1'b0});
        send(1'b1, 16'h0004, 64'h0123_4567_89AB_CDEF, tid);
        step();
        step();
    endtask

    initial begin
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        test_write();
        test_read();
        test_stray_tid();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending completions, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_initiator.md
# mmio_initiator

Host-side MMIO request generator for the CCI-P MMIO path. It takes single read/write commands over a valid/ready port and drives the c0 MMIO request fields (`mmioWrValid`, `mmioRdValid`, address, tid, data) into an AFU. For reads it waits for the matching c2 read response (`mmioRdValid` with the same tid) and returns the data. It serves as the synthesizable stimulus and loopback end for AFU bring-up and self-test.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 256: maximum number of WAIT_RSP cycles before a read completes with a timeout; must be ≥2.
- `STRAY_W`, 8: width of the saturating stray-response counter.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  16  MMIO address (CCI-P 4-byte word address).
- `cmd_data`  in  64  write data; ignored for reads.
- `mmio_wr_valid`  out  1  one-cycle write request pulse.
- `mmio_rd_valid`  out  1  one-cycle read request pulse.
- `mmio_addr`  out  16  request address.
- `mmio_length`  out  2  fixed at 2'b01 (8 bytes).
- `mmio_tid`  out  9  request transaction ID.
- `mmio_data`  out  64  write data; 0 on reads.
- `rsp_valid`  in  1  AFU read response valid (c2 `mmioRdValid`).
- `rsp_tid`  in  9  response tid.
- `rsp_data`  in  64  response data.
- `done_valid`  out  1  one-cycle completion pulse.
- `done_data`  out  64  read data; 0 for writes and for timeouts.
- `done_timeout`  out  1  qualifies `done_valid`; high when a read timed out.
- `stray_cnt`  out  `STRAY_W`  saturating count of unmatched responses.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT_RSP, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`, the block latches write, addr and data, then goes to ISSUE.
- ISSUE: exactly one of `mmio_wr_valid` or `mmio_rd_valid` is high for this single cycle, with address, tid and data valid in the same cycle.
  - Write: next state is DONE.
  - Read: next state is WAIT_RSP and the timeout counter clears to 0.
- WAIT_RSP: the block compares `rsp_valid && rsp_tid == mmio_tid` every cycle.
  - On a match, it captures `rsp_data` and goes to DONE.
  - With no match, the counter increments. If no match occurs in the cycle where the counter equals `TIMEOUT_CYCLES-1`, the block goes to DONE with the timeout flag set.
  - A match wins over a timeout in the same cycle.
- DONE: `done_valid`=1 for one cycle, then the FSM returns to IDLE.
- Tid handling:
  - The tid counter starts at 0 after reset.
  - It increments after each read ISSUE and wraps from 511 to 0.
  - Writes carry the current tid and do not increment it.
- Stray responses: any `rsp_valid` that is not a match in WAIT_RSP increments `stray_cnt`. This includes a response in any other state, a response with a wrong tid, and a late response after a timeout. `stray_cnt` saturates at all-ones.
- Reset at any point (async): FSM goes to IDLE, tid counter to 0, `stray_cnt` to 0, and all registered outputs to 0. An in-flight read is abandoned. Its later response counts as stray.

## Timing
- Reset values: `cmd_ready`=1 (decoded from IDLE); `mmio_length`=2'b01; all other outputs 0.
- Write accepted at cycle T: request pulse at T+1, `done_valid` at T+2, `cmd_ready` high again at T+3. Throughput is one write per 3 cycles.
- Read accepted at T: request pulse at T+1. A matching response at cycle R ≥ T+2 gives `done_valid` at R+1.
- A response in cycle T+1 (the ISSUE cycle) is not matched and counts as stray.
- Timeout with no response: `done_valid`/`done_timeout` at T+2+`TIMEOUT_CYCLES`.
- `mmio_addr`, `mmio_tid` and `mmio_data` hold their values outside the pulse cycle. Only the valid bits are pulses.

## Structure
- Package `mmio_init_pkg` holds:
  - the FSM state enum `mmio_init_state_e`;
  - `MMIO_TID_W`=9;
  - `MMIO_LEN_8B`=2'b01.
- This is a single module with no sub-module. The stray counter and timeout counter stay inline.

## Test plan
- Write addr 16'h0020, data 64'hA5A5_0000_1234_5678: `mmio_wr_valid` pulses at T+1 with those values and tid 0. `done_valid` at T+2 with `done_data`=0 and `done_timeout`=0.
- Read addr 16'h0020; the bench AFU returns tid 0 with data 64'hCAFE after 3 cycles: `done_data`=64'hCAFE at R+1. The next read uses tid 1.
- Read with a response carrying the wrong tid, followed by the correct tid: `stray_cnt`=1, and completion uses the correct data.
- Read with no response and `TIMEOUT_CYCLES`=8: `done_timeout`=1 and `done_data`=0 at T+10. A later response then raises `stray_cnt`.
- Perform 513 consecutive reads: tid wraps 511→0 and all reads complete.
- Assert `rst_n` low during WAIT_RSP: outputs go to 0 immediately and the FSM is in IDLE with `cmd_ready`=1. A response after reset makes `stray_cnt`=1.
